// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding and reset-cause codes.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_EXT  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;

endpackage

// File: rtl/rst_sync_cell.sv
// Async-assert / sync-deassert flop chain: output drops with rst_n at once and rises
// STAGES clock edges after rst_n is released.
module rst_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
                    sync_q <= 1'b1;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[STAGES-2:0], 1'b1};
                end
            end
        end
    endgenerate

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset generator: stretch, ordered release, software reset, cause register.
// Optional watchdog built in when RST_SEQ_WDOG_EN is defined.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int NUM_OUTS       = 3,
    parameter int STAGE_GAP      = 4,
    parameter int WDOG_CYCLES    = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sw_rst_req,
    input  logic                wdog_kick,
    output logic [NUM_OUTS-1:0] rst_out_n,
    output logic                rst_done,
    output logic [1:0]          rst_cause
);

    localparam int CW = $clog2(STRETCH_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam int IW = $clog2(NUM_OUTS + 1);

    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_OUTS - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_OUTS-1:0]   out_q, out_d;
    logic [1:0]            cause_q, cause_d;
    logic                  done_q, done_d;
    logic                  sync_rel;
    logic                  wdog_expire;
    logic                  restart;
    logic [1:0]            restart_cause;

    // The HOLD->STRETCH state edge acts as the last synchroniser stage, so the
    // cell is one flop shorter and STRETCH is entered SYNC_STAGES edges after release.
    rst_sync_cell #(
        .STAGES(SYNC_STAGES - 1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sync_o(sync_rel)
    );

`ifdef RST_SEQ_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_q, wdog_d;

    // A kick in the expiry cycle wins; the count only runs while in RUN.
    always_comb begin
        wdog_d      = '0;
        wdog_expire = 1'b0;
        if (state_q == RUN) begin
            if (wdog_kick) begin
                wdog_d = '0;
            end else if (wdog_q == WDOG_LAST) begin
                wdog_expire = 1'b1;
            end else begin
                wdog_d = wdog_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_wdog;

    assign wdog_expire = 1'b0;
    assign unused_wdog = wdog_kick & (WDOG_CYCLES > 0);
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        idx_d         = idx_q;
        out_d         = out_q;
        cause_d       = cause_q;
        restart       = 1'b0;
        restart_cause = CAUSE_SW;

        case (state_q)
            HOLD: begin
                if (sync_rel) begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end
            end
            STRETCH: begin
                if (sw_rst_req) begin
                    restart = 1'b1;
                end else if (cnt_q == STRETCH_LAST) begin
                    out_d[0] = 1'b1;
                    gap_d    = '0;
                    idx_d    = IW'(1);
                    state_d  = (NUM_OUTS == 1) ? RUN : RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (sw_rst_req) begin
                    restart = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    out_d[idx_q] = 1'b1;
                    gap_d        = '0;
                    idx_d        = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            RUN: begin
                if (sw_rst_req) begin
                    restart = 1'b1;
                end else if (wdog_expire) begin
                    restart       = 1'b1;
                    restart_cause = CAUSE_WDOG;
                end
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        // Any in-band reset event re-enters STRETCH with everything asserted.
        if (restart) begin
            state_d = STRETCH;
            cnt_d   = '0;
            gap_d   = '0;
            idx_d   = '0;
            out_d   = '0;
            cause_d = restart_cause;
        end

        done_d = (state_q == RUN) && (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            cause_q <= CAUSE_EXT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            cause_q <= cause_d;
            done_q  <= done_d;
        end
    end

    assign rst_out_n = out_q;
    assign rst_done  = done_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timing checks plus randomized traffic
// compared every cycle against an edge-arithmetic model. Build with RST_SEQ_WDOG_EN for watchdog checks.
module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int S    = 16;
    localparam int N    = 3;
    localparam int G    = 4;
    localparam int W    = 8;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         sw_rst_req = 1'b0;
    logic         wdog_kick  = 1'b0;
    logic [N-1:0] rst_out_n;
    logic         rst_done;
    logic [1:0]   rst_cause;

    int checks = 0;
    int errors = 0;

    // Model: outputs follow from the edge number of the last stretch (re)start.
    int           m_edge    = 0;
    int           m_sync    = 0;
    int           m_start   = 0;
    int           m_lz      = 0;
    bit           m_started = 1'b0;
    logic [1:0]   m_cause   = 2'b00;
    logic [N-1:0] exp_out   = '0;
    logic         exp_done  = 1'b0;

    reset_sequencer #(
        .SYNC_STAGES   (SYNC),
        .STRETCH_CYCLES(S),
        .NUM_OUTS      (N),
        .STAGE_GAP     (G),
        .WDOG_CYCLES   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_rst_req(sw_rst_req),
        .wdog_kick (wdog_kick),
        .rst_out_n (rst_out_n),
        .rst_done  (rst_done),
        .rst_cause (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync    = 0;
        m_started = 1'b0;
        m_cause   = 2'b00;
        exp_out   = '0;
        exp_done  = 1'b0;
    endtask

    task automatic model_outputs();
        int k;
        if (!m_started) begin
            exp_out  = '0;
            exp_done = 1'b0;
        end else begin
            k = m_edge - m_start;
            for (int i = 0; i < N; i++) begin
                exp_out[i] = (k >= S + i * G);
            end
            exp_done = (k >= S + (N - 1) * G + 1);
        end
    endtask

`ifdef RST_SEQ_WDOG_EN
    task automatic model_wdog();
        int run_e;
        int base;
        run_e = m_start + S + (N - 1) * G;
        if (m_edge > run_e) begin
            base = (m_lz > run_e) ? m_lz : run_e;
            if (wdog_kick) begin
                m_lz = m_edge;
            end else if (m_edge - base == W) begin
                m_start = m_edge;
                m_cause = 2'b10;
            end
        end
    endtask
`endif

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        m_edge++;
        if (!rst_n) begin
            model_reset();
        end else if (!m_started) begin
            m_sync++;
            if (m_sync == SYNC) begin
                m_started = 1'b1;
                m_start   = m_edge;
                m_lz      = 0;
            end
        end else if (sw_rst_req) begin
            m_start = m_edge;
            m_cause = 2'b01;
        end else begin
`ifdef RST_SEQ_WDOG_EN
            model_wdog();
`endif
        end
        model_outputs();
    end

    always @(negedge clk) begin
        check("cmp_rst_out_n", 32'(rst_out_n), 32'(exp_out));
        check("cmp_rst_done", 32'(rst_done), 32'(exp_done));
        check("cmp_rst_cause", 32'(rst_cause), 32'(m_cause));
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_sw();
        @(negedge clk);
        #1 sw_rst_req = 1'b1;
        @(posedge clk);
        #1 sw_rst_req = 1'b0;
    endtask

    task automatic check_asserted(input string name);
        check({name, "_out"}, 32'(rst_out_n), 32'h0);
        check({name, "_done"}, 32'(rst_done), 32'h0);
        check({name, "_cause"}, 32'(rst_cause), 32'h0);
    endtask

    task automatic drop_rst(input string name);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_asserted(name);
    endtask

    initial begin
        int r;
        int hold;
        int rate;

        // 1. Release sequence at default timing.
        repeat (5) @(negedge clk);
        check_asserted("reset_state");
        release_rst();
        edges(17); check("t1_e17", 32'(rst_out_n), 32'b000);
        edges(1);  check("t1_e18", 32'(rst_out_n), 32'b001);
        edges(3);  check("t1_e21", 32'(rst_out_n), 32'b001);
        edges(1);  check("t1_e22", 32'(rst_out_n), 32'b011);
        edges(4);  check("t1_e26", 32'(rst_out_n), 32'b111);
                   check("t1_e26_done", 32'(rst_done), 32'h0);
        edges(1);  check("t1_e27_done", 32'(rst_done), 32'h1);
                   check("t1_cause", 32'(rst_cause), 32'h0);

        // 2. Software reset from RUN.
        pulse_sw();
        check("t2_out", 32'(rst_out_n), 32'b000);
        check("t2_done", 32'(rst_done), 32'h0);
        check("t2_cause", 32'(rst_cause), 32'h1);
        edges(15); check("t2_p15", 32'(rst_out_n), 32'b000);
        edges(1);  check("t2_p16", 32'(rst_out_n), 32'b001);
        edges(12); check("t2_done_again", 32'(rst_done), 32'h1);

        // 3. External reset mid-release.
        pulse_sw();
        edges(20); check("t3_pre", 32'(rst_out_n), 32'b011);
        drop_rst("t3_async");
        repeat (3) @(negedge clk);
        release_rst();
        edges(18); check("t3_e18", 32'(rst_out_n), 32'b001);
        edges(9);  check("t3_e27_done", 32'(rst_done), 32'h1);
                   check("t3_cause", 32'(rst_cause), 32'h0);

        // 4a. sw_rst_req in HOLD is ignored.
        drop_rst("t4_drop");
        repeat (2) @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        sw_rst_req = 1'b1;
        edges(2);
        sw_rst_req = 1'b0;
        edges(15); check("t4h_e17", 32'(rst_out_n), 32'b000);
        edges(1);  check("t4h_e18", 32'(rst_out_n), 32'b001);
                   check("t4h_cause", 32'(rst_cause), 32'h0);

        // 4b. sw_rst_req ten cycles into STRETCH delays release by ten cycles.
        drop_rst("t4s_drop");
        release_rst();
        edges(11);
        pulse_sw();
        edges(15); check("t4s_e27", 32'(rst_out_n), 32'b000);
        edges(1);  check("t4s_e28", 32'(rst_out_n), 32'b001);
                   check("t4s_cause", 32'(rst_cause), 32'h1);
        edges(15); check("t4s_e43", 32'(rst_out_n), 32'b111);
                   check("t4s_e43_done", 32'(rst_done), 32'h1);

        // 5. Watchdog: expiry eight cycles into RUN, then regular kicks.
        edges(1);
`ifdef RST_SEQ_WDOG_EN
        check("t5_fire_out", 32'(rst_out_n), 32'b000);
        check("t5_fire_cause", 32'(rst_cause), 32'h2);
`else
        check("t5_nowdog_out", 32'(rst_out_n), 32'b111);
        check("t5_nowdog_cause", 32'(rst_cause), 32'h1);
`endif
        for (int j = 0; j < 90; j++) begin
            @(negedge clk);
            #1 wdog_kick = (j % 5 == 0);
        end
        edges(1);
        wdog_kick = 1'b0;
        check("t5_kick_done", 32'(rst_done), 32'h1);
`ifdef RST_SEQ_WDOG_EN
        check("t5_kick_cause", 32'(rst_cause), 32'h2);
`else
        check("t5_kick_cause", 32'(rst_cause), 32'h1);
`endif
        @(negedge clk);
        #1 wdog_kick = 1'b1;
        sw_rst_req = 1'b1;
        @(posedge clk);
        #1 wdog_kick = 1'b0;
        sw_rst_req = 1'b0;
        check("t5_kick_sw_cause", 32'(rst_cause), 32'h1);
        check("t5_kick_sw_out", 32'(rst_out_n), 32'b000);

        // 6. 1-unit glitch on rst_n between edges.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_asserted("t6_glitch");
        rst_n = 1'b1;
        edges(17); check("t6_e17", 32'(rst_out_n), 32'b000);
        edges(1);  check("t6_e18", 32'(rst_out_n), 32'b001);
        edges(9);  check("t6_e27_done", 32'(rst_done), 32'h1);
                   check("t6_cause", 32'(rst_cause), 32'h0);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            rate = (c < 1500) ? 40 : 150;
            @(negedge clk);
            #1;
            sw_rst_req = ($urandom_range(0, rate - 1) == 0);
            wdog_kick  = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 299);
            if (r == 0) begin
                #1 rst_n = 1'b0;
                #1 check_asserted("rnd_glitch");
                rst_n = 1'b1;
            end else if (r == 1) begin
                #1 rst_n = 1'b0;
                #1 check_asserted("rnd_drop");
                hold = $urandom_range(1, 4);
                repeat (hold) @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        sw_rst_req = 1'b0;
        wdog_kick  = 1'b0;
        edges(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
